// File: rtl/hw_sensor_pkg.sv
// Shared types, address map and helpers for the sensor register bank.
package hw_sensor_pkg;

  typedef logic [31:0] sensor_word_t;

  // CTRL layout: freeze is bit 0, clr_minmax is bit 1
  typedef struct packed {
    logic clr_minmax;
    logic freeze;
  } ctrl_t;

  localparam logic [31:0] LP_VALUE_BASE  = 32'h000;
  localparam logic [31:0] LP_THR_HI_BASE = 32'h100;
  localparam logic [31:0] LP_THR_LO_BASE = 32'h180;
  localparam logic [31:0] LP_ALARM_ADDR  = 32'h200;
  localparam logic [31:0] LP_IRQ_EN_ADDR = 32'h204;
  localparam logic [31:0] LP_CTRL_ADDR   = 32'h208;
  localparam logic [31:0] LP_INFO_ADDR   = 32'h20C;
  localparam logic [31:0] LP_MIN_BASE    = 32'h280;
  localparam logic [31:0] LP_MAX_BASE    = 32'h300;

  // True when addr falls inside a window of n consecutive 32-bit words
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned n);
    return (addr >= base) && (addr < (base + (n << 2)));
  endfunction

  // a < b, two's-complement when sgn is set
  function automatic logic word_lt(input sensor_word_t a,
                                   input sensor_word_t b,
                                   input logic sgn);
    return sgn ? ($signed(a) < $signed(b)) : (a < b);
  endfunction

endpackage

// File: rtl/hw_sensor_chan.sv
// One sensor channel: snapshot, thresholds, compare and optional min/max.
// Optional feature: HW_SENSOR_MINMAX_EN adds running MIN/MAX tracking.
module hw_sensor_chan
  import hw_sensor_pkg::*;
#(
  parameter int P_SIGNED = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_sample,
  input  sensor_word_t i_data,
  input  logic         i_hi_we,
  input  logic         i_lo_we,
  input  sensor_word_t i_wdata,
`ifdef HW_SENSOR_MINMAX_EN
  input  logic         i_clr_minmax,
  output sensor_word_t o_min,
  output sensor_word_t o_max,
`endif
  output sensor_word_t o_snap,
  output sensor_word_t o_hi,
  output sensor_word_t o_lo,
  output logic         o_alarm_set
);

  localparam logic         LP_SGN = (P_SIGNED != 0);
  localparam sensor_word_t LP_TOP = LP_SGN ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
  localparam sensor_word_t LP_BOT = LP_SGN ? 32'h8000_0000 : 32'h0000_0000;

  sensor_word_t r_snap;
  sensor_word_t r_hi;
  sensor_word_t r_lo;
  logic         r_cmp_pend;

  // Snapshot capture and threshold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap     <= '0;
      r_hi       <= LP_TOP;
      r_lo       <= LP_BOT;
      r_cmp_pend <= 1'b0;
    end else begin
      r_cmp_pend <= i_sample;
      if (i_sample) r_snap <= i_data;
      if (i_hi_we)  r_hi   <= i_wdata;
      if (i_lo_we)  r_lo   <= i_wdata;
    end
  end

  // Compare the fresh snapshot against current thresholds; equality is in range
  always_comb begin
    o_alarm_set = r_cmp_pend &
                  (word_lt(r_hi, r_snap, LP_SGN) | word_lt(r_snap, r_lo, LP_SGN));
  end

  assign o_snap = r_snap;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

`ifdef HW_SENSOR_MINMAX_EN
  sensor_word_t r_min;
  sensor_word_t r_max;

  // Running extremes; a clear coinciding with a sample re-seeds from that sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_min <= LP_TOP;
      r_max <= LP_BOT;
    end else if (i_clr_minmax && i_sample) begin
      r_min <= i_data;
      r_max <= i_data;
    end else if (i_clr_minmax) begin
      r_min <= LP_TOP;
      r_max <= LP_BOT;
    end else if (i_sample) begin
      if (word_lt(i_data, r_min, LP_SGN)) r_min <= i_data;
      if (word_lt(r_max, i_data, LP_SGN)) r_max <= i_data;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;
`endif

endmodule

// File: rtl/hw_sensor_regbank.sv
// APB sensor register bank with sticky W1C alarms, interrupt and PSLVERR.
// Optional feature: HW_SENSOR_MINMAX_EN maps per-channel MIN/MAX windows.
module hw_sensor_regbank
  import hw_sensor_pkg::*;
#(
  parameter int P_NO_CH            = 8,
  parameter int P_SIGNED           = 0,
  parameter int P_S_AXI_ADDR_WIDTH = 10,
  parameter int P_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic [P_NO_CH-1:0][31:0]      sensor_info,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic                          s_apb_pwrite,
  input  logic                          s_apb_psel,
  input  logic                          s_apb_penable,
  input  logic [P_S_AXI_DATA_WIDTH-1:0] s_apb_pwdata,
  output logic [P_S_AXI_DATA_WIDTH-1:0] s_apb_prdata,
  output logic                          s_apb_pready,
  output logic                          s_apb_pslverr,
  output logic                          irq
);

  localparam logic LP_SGN = (P_SIGNED != 0);

  logic [31:0]        w_addr;
  logic [4:0]         w_idx;
  logic               w_setup;
  logic               w_access;
  logic               w_in_val, w_in_hi, w_in_lo, w_in_min, w_in_max;
  logic               w_is_alarm, w_is_irqen, w_is_ctrl, w_is_info;
  logic               w_mapped, w_ro, w_err, w_wr;
  logic [31:0]        w_rdata;
  logic               w_sample;
  logic               w_clr_minmax;
  logic [P_NO_CH-1:0] w_alarm_set;
  logic [P_NO_CH-1:0] w_alarm_clr;

  sensor_word_t w_snap [P_NO_CH];
  sensor_word_t w_hi   [P_NO_CH];
  sensor_word_t w_lo   [P_NO_CH];
  sensor_word_t w_min  [P_NO_CH];
  sensor_word_t w_max  [P_NO_CH];

  logic [31:0]        r_prdata;
  logic               r_pslverr;
  logic [P_NO_CH-1:0] r_alarm;
  logic [P_NO_CH-1:0] r_irq_en;
  ctrl_t              r_ctrl;
  logic               r_irq;

  assign w_addr   = 32'(s_apb_paddr) & ~32'h3;
  assign w_idx    = w_addr[6:2];
  assign w_setup  = s_apb_psel & ~s_apb_penable;
  assign w_access = s_apb_psel & s_apb_penable;

  // Address decode and error classification
  always_comb begin
    w_in_val   = in_window(w_addr, LP_VALUE_BASE,  P_NO_CH);
    w_in_hi    = in_window(w_addr, LP_THR_HI_BASE, P_NO_CH);
    w_in_lo    = in_window(w_addr, LP_THR_LO_BASE, P_NO_CH);
`ifdef HW_SENSOR_MINMAX_EN
    w_in_min   = in_window(w_addr, LP_MIN_BASE,    P_NO_CH);
    w_in_max   = in_window(w_addr, LP_MAX_BASE,    P_NO_CH);
`else
    w_in_min   = 1'b0;
    w_in_max   = 1'b0;
`endif
    w_is_alarm = (w_addr == LP_ALARM_ADDR);
    w_is_irqen = (w_addr == LP_IRQ_EN_ADDR);
    w_is_ctrl  = (w_addr == LP_CTRL_ADDR);
    w_is_info  = (w_addr == LP_INFO_ADDR);
    w_mapped   = w_in_val | w_in_hi | w_in_lo | w_in_min | w_in_max |
                 w_is_alarm | w_is_irqen | w_is_ctrl | w_is_info;
    w_ro       = w_in_val | w_in_min | w_in_max | w_is_info;
    w_err      = ~w_mapped | (s_apb_pwrite & w_ro);
    w_wr       = w_access & s_apb_pwrite & ~w_err;
  end

  assign w_sample = sample_valid & ~r_ctrl.freeze;
`ifdef HW_SENSOR_MINMAX_EN
  assign w_clr_minmax = w_wr & w_is_ctrl & s_apb_pwdata[1];
`else
  assign w_clr_minmax = 1'b0;
`endif

  for (genvar gi = 0; gi < P_NO_CH; gi++) begin : g_chan
    hw_sensor_chan #(.P_SIGNED(P_SIGNED)) u_chan (
      .clk          (clk),
      .reset        (reset),
      .i_sample     (w_sample),
      .i_data       (sensor_info[gi]),
      .i_hi_we      (w_wr & w_in_hi & (w_idx == 5'(gi))),
      .i_lo_we      (w_wr & w_in_lo & (w_idx == 5'(gi))),
      .i_wdata      (s_apb_pwdata[31:0]),
`ifdef HW_SENSOR_MINMAX_EN
      .i_clr_minmax (w_clr_minmax),
      .o_min        (w_min[gi]),
      .o_max        (w_max[gi]),
`endif
      .o_snap       (w_snap[gi]),
      .o_hi         (w_hi[gi]),
      .o_lo         (w_lo[gi]),
      .o_alarm_set  (w_alarm_set[gi])
    );
`ifndef HW_SENSOR_MINMAX_EN
    assign w_min[gi] = '0;
    assign w_max[gi] = '0;
`endif
  end

  // Read mux; unmapped addresses fall through to zero
  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < P_NO_CH; i++) begin
      if (w_idx == 5'(i)) begin
        if (w_in_val) w_rdata = w_snap[i];
        if (w_in_hi)  w_rdata = w_hi[i];
        if (w_in_lo)  w_rdata = w_lo[i];
        if (w_in_min) w_rdata = w_min[i];
        if (w_in_max) w_rdata = w_max[i];
      end
    end
    if (w_is_alarm) w_rdata = 32'(r_alarm);
    if (w_is_irqen) w_rdata = 32'(r_irq_en);
    if (w_is_ctrl)  w_rdata = 32'(r_ctrl);
    if (w_is_info)  w_rdata = {LP_SGN, 15'b0, 16'(P_NO_CH)};
  end

  // Read data captured in the setup phase, held between transfers
  always_ff @(posedge clk) begin
    if (reset)                        r_prdata <= '0;
    else if (w_setup && !s_apb_pwrite) r_prdata <= w_rdata;
  end

  // Error captured in the setup phase, presented alongside pready
  always_ff @(posedge clk) begin
    if (reset)        r_pslverr <= 1'b0;
    else if (w_setup) r_pslverr <= w_err;
  end

  assign w_alarm_clr = (w_wr && w_is_alarm) ? s_apb_pwdata[P_NO_CH-1:0] : '0;

  // Sticky alarms: a coincident set overrides the W1C clear
  always_ff @(posedge clk) begin
    if (reset) r_alarm <= '0;
    else       r_alarm <= (r_alarm & ~w_alarm_clr) | w_alarm_set;
  end

  // IRQ_EN and CTRL; clr_minmax is a pulse and never stored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en <= '0;
      r_ctrl   <= '0;
    end else begin
      if (w_wr && w_is_irqen) r_irq_en <= s_apb_pwdata[P_NO_CH-1:0];
      if (w_wr && w_is_ctrl) begin
        r_ctrl.freeze     <= s_apb_pwdata[0];
        r_ctrl.clr_minmax <= 1'b0;
      end
    end
  end

  // Registered interrupt
  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= |(r_alarm & r_irq_en);
  end

  assign s_apb_prdata  = r_prdata;
  assign s_apb_pready  = w_access;
  assign s_apb_pslverr = r_pslverr & w_access;
  assign irq           = r_irq;

endmodule

// File: tb/tb_hw_sensor_regbank.sv
// Scoreboard bench: unsigned and signed instances share clock, reset and APB bus.
module tb_hw_sensor_regbank;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sv_u = 1'b0, sv_s = 1'b0;
  logic [7:0][31:0] info = '0;
  logic [9:0]      paddr = '0;
  logic            pwrite = 1'b0, penable = 1'b0;
  logic            psel_u = 1'b0, psel_s = 1'b0;
  logic [31:0]     pwdata = '0;
  logic [31:0]     prdata_u, prdata_s;
  logic            pready_u, pready_s, pslverr_u, pslverr_s, irq_u, irq_s;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        err;
    bit          chk_data;
    string       name;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hw_sensor_regbank #(.P_NO_CH(8), .P_SIGNED(0), .P_S_AXI_ADDR_WIDTH(10), .P_S_AXI_DATA_WIDTH(32)) u_dut_u (
    .clk(clk), .reset(reset), .sample_valid(sv_u), .sensor_info(info),
    .s_apb_paddr(paddr), .s_apb_pwrite(pwrite), .s_apb_psel(psel_u), .s_apb_penable(penable),
    .s_apb_pwdata(pwdata), .s_apb_prdata(prdata_u), .s_apb_pready(pready_u),
    .s_apb_pslverr(pslverr_u), .irq(irq_u));

  hw_sensor_regbank #(.P_NO_CH(8), .P_SIGNED(1), .P_S_AXI_ADDR_WIDTH(10), .P_S_AXI_DATA_WIDTH(32)) u_dut_s (
    .clk(clk), .reset(reset), .sample_valid(sv_s), .sensor_info(info),
    .s_apb_paddr(paddr), .s_apb_pwrite(pwrite), .s_apb_psel(psel_s), .s_apb_penable(penable),
    .s_apb_pwdata(pwdata), .s_apb_prdata(prdata_s), .s_apb_pready(pready_s),
    .s_apb_pslverr(pslverr_s), .irq(irq_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // strobe: 0 none, 1 sample_valid during setup, 2 sample_valid during access
  task automatic apb(input int dut, input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_err, input bit chk_data,
                     input int strobe, input string name);
    exp_t e;
    e.dut = dut; e.data = exp_data; e.err = exp_err; e.chk_data = chk_data; e.name = name;
    q.push_back(e);
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
    if (dut == 0) psel_u = 1'b1; else psel_s = 1'b1;
    if (strobe == 1) begin if (dut == 0) sv_u = 1'b1; else sv_s = 1'b1; end
    @(posedge clk); #1;
    penable = 1'b1; sv_u = 1'b0; sv_s = 1'b0;
    if (strobe == 2) begin if (dut == 0) sv_u = 1'b1; else sv_s = 1'b1; end
    @(posedge clk); #1;
    psel_u = 1'b0; psel_s = 1'b0; penable = 1'b0; sv_u = 1'b0; sv_s = 1'b0;
  endtask

  task automatic rd(input int dut, input logic [9:0] a, input logic [31:0] exp, input string name);
    apb(dut, 1'b0, a, 32'h0, exp, 1'b0, 1'b1, 0, name);
  endtask
  task automatic rde(input int dut, input logic [9:0] a, input string name);
    apb(dut, 1'b0, a, 32'h0, 32'h0, 1'b1, 1'b1, 0, name);
  endtask
  task automatic wr(input int dut, input logic [9:0] a, input logic [31:0] d, input string name);
    apb(dut, 1'b1, a, d, 32'h0, 1'b0, 1'b0, 0, name);
  endtask
  task automatic wre(input int dut, input logic [9:0] a, input logic [31:0] d, input string name);
    apb(dut, 1'b1, a, d, 32'h0, 1'b1, 1'b0, 0, name);
  endtask

  task automatic sample(input int dut);
    @(posedge clk); #1;
    if (dut == 0) sv_u = 1'b1; else sv_s = 1'b1;
    @(posedge clk); #1;
    sv_u = 1'b0; sv_s = 1'b0;
  endtask

  // Monitor: pop one expectation for every completed APB transfer
  initial begin
    forever begin
      @(negedge clk);
      if (pready_u || pready_s) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_response pready_u=%b pready_s=%b", pready_u, pready_s);
        end else begin
          exp_t e;
          logic [31:0] d;
          logic        er;
          logic        rdy;
          e   = q.pop_front();
          d   = (e.dut == 0) ? prdata_u  : prdata_s;
          er  = (e.dut == 0) ? pslverr_u : pslverr_s;
          rdy = (e.dut == 0) ? pready_u  : pready_s;
          checks++;
          if (!rdy) begin
            failures++;
            $display("FAIL %s_ready dut=%0d actual=0 expected=1", e.name, e.dut);
          end
          checks++;
          if (er !== e.err) begin
            failures++;
            $display("FAIL %s_pslverr dut=%0d actual=%b expected=%b", e.name, e.dut, er, e.err);
          end
          if (e.chk_data) begin
            checks++;
            if (d !== e.data) begin
              failures++;
              $display("FAIL %s_prdata dut=%0d actual=%h expected=%h", e.name, e.dut, d, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout pending=%0d", q.size());
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_prdata",  prdata_u, 32'h0);
    chk("reset_pslverr", {31'b0, pslverr_u}, 32'h0);
    chk("reset_irq",     {31'b0, irq_u}, 32'h0);

    // Reset values and INFO
    rd(0, 10'h20C, 32'h0000_0008, "info_u");
    rd(0, 10'h100, 32'hFFFF_FFFF, "thr_hi0_u");
    rd(1, 10'h20C, 32'h8000_0008, "info_s");
    rd(1, 10'h100, 32'h7FFF_FFFF, "thr_hi0_s");
    rd(1, 10'h180, 32'h8000_0000, "thr_lo0_s");

    // Unsigned alarm path and irq latency
    wr(0, 10'h108, 32'd100, "wr_thr_hi2");
    wr(0, 10'h204, 32'h4, "wr_irq_en");
    info[0] = 32'h55; info[2] = 32'd101;
    sample(0);
    @(posedge clk); #1 chk("irq_one_after", {31'b0, irq_u}, 32'h0);
    @(posedge clk); #1 chk("irq_two_after", {31'b0, irq_u}, 32'h1);
    rd(0, 10'h200, 32'h4, "alarm_set");
    rd(0, 10'h008, 32'd101, "value2");

    // Clear coinciding with a new set: set wins
    info[2] = 32'd150;
    apb(0, 1'b1, 10'h200, 32'h4, 32'h0, 1'b0, 1'b0, 1, "w1c_vs_set");
    rd(0, 10'h200, 32'h4, "alarm_after_race");
    chk("irq_still_set", {31'b0, irq_u}, 32'h1);

    // Equality is not an alarm; clear then takes effect
    info[2] = 32'd100;
    sample(0);
    wr(0, 10'h200, 32'h4, "w1c_clear");
    rd(0, 10'h200, 32'h0, "alarm_cleared");
    chk("irq_cleared", {31'b0, irq_u}, 32'h0);

    // Errors
    rd(0, 10'h000, 32'h55, "value0");
    rde(0, 10'h020, "rd_ch8");
    wre(0, 10'h000, 32'hDEAD_BEEF, "wr_value_ro");
    rd(0, 10'h000, 32'h55, "value0_unchanged");
    wre(0, 10'h20C, 32'h1, "wr_info_ro");
    rde(0, 10'h17C, "rd_thr_hi_ch31");
    rd(0, 10'h11C, 32'hFFFF_FFFF, "thr_hi7");
    wr(0, 10'h204, 32'hFFFF_FFFF, "wr_irq_en_all");
    rd(0, 10'h204, 32'h0000_00FF, "irq_en_masked");

    // Freeze
    wr(0, 10'h208, 32'h1, "wr_freeze");
    rd(0, 10'h208, 32'h1, "ctrl_freeze");
    info[0] = 32'h77;
    sample(0);
    rd(0, 10'h000, 32'h55, "value_frozen");
    wr(0, 10'h208, 32'h0, "wr_unfreeze");
    sample(0);
    rd(0, 10'h000, 32'h77, "value_unfrozen");
    wr(0, 10'h208, 32'h2, "wr_clr_minmax");
    rd(0, 10'h208, 32'h0, "ctrl_clr_reads0");

`ifdef HW_SENSOR_MINMAX_EN
    info[1] = 32'd10; sample(0);
    info[1] = 32'd3;  sample(0);
    info[1] = 32'd7;  sample(0);
    rd(0, 10'h284, 32'd3,  "min1");
    rd(0, 10'h304, 32'd10, "max1");
    info[1] = 32'd5;
    apb(0, 1'b1, 10'h208, 32'h2, 32'h0, 1'b0, 1'b0, 2, "clr_with_sample");
    rd(0, 10'h284, 32'd5, "min1_reseed");
    rd(0, 10'h304, 32'd5, "max1_reseed");
    wre(0, 10'h284, 32'h1, "wr_min_ro");
`else
    rde(0, 10'h284, "rd_min_unmapped");
    rde(0, 10'h304, "rd_max_unmapped");
`endif

    // Signed compare
    wr(1, 10'h180, 32'hFFFF_FFFB, "wr_thr_lo0_s");
    info[0] = 32'hFFFF_FFFA;
    sample(1);
    rd(1, 10'h200, 32'h1, "alarm_signed");
    wr(1, 10'h200, 32'h1, "w1c_signed");
    rd(1, 10'h200, 32'h0, "alarm_signed_clr");
    info[0] = 32'hFFFF_FFFB;
    sample(1);
    rd(1, 10'h200, 32'h0, "alarm_signed_eq");
    info[0] = 32'h0000_0005;
    sample(1);
    rd(1, 10'h200, 32'h0, "alarm_signed_pos");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
